// File: rtl/sha1_pad_pkg.sv
// Shared types and constants for the SHA-1 message padder.
package sha1_pad_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        PAD   = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4
    } PadState;

    localparam int         BLOCK_BYTES = 64;
    localparam int         LEN_OFFSET  = 56;
    localparam logic [7:0] PAD_BYTE    = 8'h80;

    // MSB position of byte lane k in a 512-bit big-endian block
    function automatic int lane_hi(input logic [5:0] idx);
        return 511 - 8 * int'(idx);
    endfunction

endpackage

// File: rtl/sha1_msg_padder.sv
// Packs a framed byte stream into 512-bit SHA-1 blocks with length padding
// and sequences init/next pulses against the hash core's ready.
//
// state | meaning
// IDLE  | between messages; re-arms counters, one cycle
// FILL  | accepting message bytes into the current block
// PAD   | placing 0x80 and/or the bit length into the current block
// ISSUE | block complete, waiting for core_ready to pulse init/next
// WAIT  | core busy with the block; block held stable
module sha1_msg_padder
    import sha1_pad_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [7:0]   s_axis_tdata,
    input  logic         s_axis_tvalid,
    input  logic         s_axis_tlast,
    output logic         s_axis_tready,
    input  logic         core_ready,
    output logic         init,
    output logic         next,
    output logic [511:0] block,
    output logic         msg_done,
    output logic         busy
);

    PadState          state;
    PadState          state_nxt;
    logic [6:0]       byte_idx;
    logic [LEN_W-1:0] bit_len;
    logic             first_blk;
    logic             last_blk;
    logic             pad_80;
    logic             pad_len;
    logic             wait_first;
    logic             accept;

    assign s_axis_tready = (state == FILL);
    assign accept        = s_axis_tvalid & s_axis_tready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = FILL;
            FILL: begin
                if (accept) begin
                    if (s_axis_tlast)
                        state_nxt = PAD;
                    else if (byte_idx == 7'(BLOCK_BYTES - 1))
                        state_nxt = ISSUE;
                end
            end
            PAD:   state_nxt = ISSUE;
            ISSUE: if (core_ready) state_nxt = WAIT;
            WAIT: begin
                if (!wait_first && core_ready) begin
                    if (last_blk)
                        state_nxt = IDLE;
                    else if (pad_len)
                        state_nxt = PAD;
                    else
                        state_nxt = FILL;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            block      <= '0;
            byte_idx   <= '0;
            bit_len    <= '0;
            first_blk  <= 1'b0;
            last_blk   <= 1'b0;
            pad_80     <= 1'b0;
            pad_len    <= 1'b0;
            wait_first <= 1'b0;
            init       <= 1'b0;
            next       <= 1'b0;
            msg_done   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt != IDLE);
            init     <= 1'b0;
            next     <= 1'b0;
            msg_done <= 1'b0;
            case (state)
                IDLE: begin
                    bit_len   <= '0;
                    byte_idx  <= '0;
                    first_blk <= 1'b1;
                    last_blk  <= 1'b0;
                    pad_80    <= 1'b0;
                    pad_len   <= 1'b0;
                end
                FILL: begin
                    if (accept) begin
                        block[lane_hi(byte_idx[5:0]) -: 8] <= s_axis_tdata;
                        byte_idx <= byte_idx + 7'd1;
                        bit_len  <= bit_len + LEN_W'(8);
                        if (s_axis_tlast) begin
                            pad_80  <= 1'b1;
                            pad_len <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    // a full block (p==64) defers the 0x80 to the next block
                    if (pad_80 && byte_idx != 7'(BLOCK_BYTES)) begin
                        block[lane_hi(byte_idx[5:0]) -: 8] <= PAD_BYTE;
                        pad_80 <= 1'b0;
                    end
                    if (pad_len && byte_idx < 7'(LEN_OFFSET)) begin
                        block[63:0] <= 64'(bit_len);
                        pad_len     <= 1'b0;
                        last_blk    <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (core_ready) begin
                        init       <= first_blk;
                        next       <= ~first_blk;
                        first_blk  <= 1'b0;
                        wait_first <= 1'b1;
                    end
                end
                WAIT: begin
                    if (wait_first) begin
                        wait_first <= 1'b0;
                    end else if (core_ready) begin
                        block    <= '0;
                        byte_idx <= '0;
                        msg_done <= last_blk;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Self-checking bench for sha1_msg_padder: directed and random messages
// compared against a byte-level padding model.
module tb_sha1_msg_padder;

    typedef logic [7:0] bq_t[$];

    logic         clk = 1'b0;
    logic         reset_n;
    logic [7:0]   s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tready;
    logic         core_ready;
    logic         init;
    logic         next;
    logic [511:0] block;
    logic         msg_done;
    logic         busy;

    sha1_msg_padder #(.LEN_W(64)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .core_ready    (core_ready),
        .init          (init),
        .next          (next),
        .block         (block),
        .msg_done      (msg_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           bad   = 0;
    logic [511:0] exp_q[$];
    int           blk_cnt  = 0;
    int           done_cnt = 0;
    int           core_cnt = 0;
    bit           hold     = 1'b0;
    logic [511:0] last_pulse_blk = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Padded message = data, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length
    function automatic void build_exp(input bq_t m);
        bq_t          p;
        logic [63:0]  len;
        logic [511:0] blk;
        p = m;
        len = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(len[8*i +: 8]);
        exp_q.delete();
        for (int b = 0; b < p.size() / 64; b++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*b + j];
            exp_q.push_back(blk);
        end
        blk_cnt = 0;
    endfunction

    // One clock: observe at negedge, run the core model, leave driving to the caller
    task automatic tick();
        @(negedge clk);
        if (init || next) begin
            chk("init_on_first", 64'(init), 64'(blk_cnt == 0));
            chk("next_on_later", 64'(next), 64'(blk_cnt != 0));
            chk("blk_in_range", 64'(blk_cnt < exp_q.size()), 64'd1);
            if (blk_cnt < exp_q.size())
                chk_blk("block", block, exp_q[blk_cnt]);
            last_pulse_blk = block;
            blk_cnt++;
            core_cnt = $urandom_range(1, 6);
        end
        if (msg_done) begin
            chk("done_blocks", 64'(blk_cnt), 64'(exp_q.size()));
            chk("busy_at_done", 64'(busy), 64'd0);
            done_cnt++;
        end
        if (core_cnt > 0) core_cnt--;
        core_ready = !hold && (core_cnt == 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        forever begin
            tick();
            s_axis_tdata  = b;
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = last;
            if (s_axis_tready) break;
            n++;
            if (n > 3000) begin
                chk("byte_accept_timeout", 64'(s_axis_tready), 64'd1);
                break;
            end
        end
    endtask

    task automatic send_bytes(input bq_t m, input bit with_last);
        for (int i = 0; i < m.size(); i++)
            send_byte(m[i], with_last && (i == m.size() - 1));
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_done();
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < 5000) begin
            tick();
            n++;
        end
        chk("msg_done_seen", 64'(done_cnt), 64'(start + 1));
    endtask

    task automatic run_msg(input bq_t m);
        build_exp(m);
        send_bytes(m, 1'b1);
        wait_done();
    endtask

    initial begin
        bq_t          m;
        logic [511:0] blk_hold;
        logic [511:0] part;
        logic [511:0] abc_blk;
        abc_blk = {32'h61626380, 416'h0, 64'h18};

        reset_n       = 1'b0;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        core_ready    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_init", 64'(init), 64'd0);
        chk("rst_next", 64'(next), 64'd0);
        chk("rst_done", 64'(msg_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk_blk("rst_block", block, '0);
        reset_n = 1'b1;
        repeat (2) tick();
        chk("busy_after_rst", 64'(busy), 64'd1);

        // "abc"
        m = '{8'h61, 8'h62, 8'h63};
        run_msg(m);
        chk_blk("abc_block", last_pulse_blk, abc_blk);
        chk("abc_blocks", 64'(blk_cnt), 64'd1);

        // 55, 56 and 64 byte boundaries
        foreach (m[i]) ;
        m.delete();
        for (int i = 0; i < 55; i++) m.push_back(8'(i));
        run_msg(m);
        chk("len55_blocks", 64'(blk_cnt), 64'd1);
        chk("len55_field", last_pulse_blk[63:0], 64'h1B8);
        m.push_back(8'(55));
        run_msg(m);
        chk("len56_blocks", 64'(blk_cnt), 64'd2);
        chk_blk("len56_last", last_pulse_blk, {448'h0, 64'h1C0});
        for (int i = 56; i < 64; i++) m.push_back(8'(i));
        run_msg(m);
        chk("len64_blocks", 64'(blk_cnt), 64'd2);
        chk_blk("len64_last", last_pulse_blk, {8'h80, 440'h0, 64'h200});

        // core_ready held low during ISSUE
        hold = 1'b1;
        m = '{8'h11, 8'h22, 8'h33};
        build_exp(m);
        send_bytes(m, 1'b1);
        tick();
        blk_hold = block;
        chk_blk("hold_block", blk_hold, exp_q[0]);
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("hold_tready", 64'(s_axis_tready), 64'd0);
            chk("hold_no_pulse", 64'(init | next), 64'd0);
            chk_blk("hold_stable", block, blk_hold);
        end
        hold = 1'b0;
        wait_done();

        // reset mid-FILL after 10 bytes
        m.delete();
        part = '0;
        for (int i = 0; i < 10; i++) begin
            m.push_back(8'($urandom));
            part[511 - 8*i -: 8] = m[i];
        end
        build_exp(m);
        send_bytes(m, 1'b0);
        chk_blk("partial_block", block, part);
        #2 reset_n = 1'b0;
        #1;
        chk_blk("midrst_block", block, '0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_tready", 64'(s_axis_tready), 64'd0);
        chk("midrst_pulses", 64'({init, next, msg_done}), 64'd0);
        repeat (2) @(negedge clk);
        core_cnt = 0;
        reset_n  = 1'b1;
        m = '{8'h61, 8'h62, 8'h63};
        run_msg(m);
        chk_blk("abc_after_rst", last_pulse_blk, abc_blk);

        // random messages, random core latency
        for (int t = 0; t < 10; t++) begin
            int len;
            len = $urandom_range(1, 200);
            m.delete();
            for (int i = 0; i < len; i++) m.push_back(8'($urandom));
            run_msg(m);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
